// File: rtl/chunked_add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM states and opcodes.
package chunked_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunked_add_sub_if.sv
// Request/result bundle for chunked_add_sub: operands and opcode in,
// handshake, result and status flags out.
interface chunked_add_sub_if #(
  parameter int WIDTH = 32
) ();

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SnA;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] Y;
  logic             CO;
  logic             ZERO;
  logic             NEG;
  logic             OVF;

  modport master (
    output START, A, B, SnA,
    input  BUSY, DONE, Y, CO, ZERO, NEG, OVF
  );

  modport slave (
    input  START, A, B, SnA,
    output BUSY, DONE, Y, CO, ZERO, NEG, OVF
  );

endinterface

// File: rtl/chunked_add_sub_rc_add_chunk.sv
// Combinational N-bit ripple-carry adder slice. Also exposes the carry into
// the top bit so the parent can derive signed overflow on the last slice.
module rc_add_chunk #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_s,
  output logic         o_co,
  output logic         o_c_msb
);

  logic [N:0] w_c;

  // Ripple the carry from bit 0 upward.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < N; i++) begin
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_s     = i_a ^ i_b ^ w_c[N-1:0];
  assign o_co    = w_c[N];
  assign o_c_msb = w_c[N-1];

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: processes a WIDTH-bit add or subtract CHUNK
// bits per cycle, LSB slice first, with the carry held in a register between
// slices. Subtraction uses A + ~B + 1, so CO=1 means "no borrow".
module chunked_add_sub
  import chunked_add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic              CLK,
  input logic              RST,
  chunked_add_sub_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_add_sub: WIDTH must be a whole multiple of CHUNK");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_y_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_co;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_c_msb;

  // Next-state decode; a START is only honoured when not mid-run.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = (r_cnt == CW'(NCHUNK - 1));
    case (r_state)
      ST_IDLE: begin
        if (bus.START) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        if (bus.START) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset wins in every state and aborts a run silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture; B is pre-inverted for subtract so every slice just adds.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_a <= bus.A;
      r_b <= bus.B ^ {WIDTH{bus.SnA}};
    end
  end

  // Select the active slice and splice its sum into the running result.
  always_comb begin
    w_base  = 32'(r_cnt) * 32'(CHUNK);
    w_a_sl  = r_a[w_base +: CHUNK];
    w_b_sl  = r_b[w_base +: CHUNK];
    w_y_nxt = r_y;
    w_y_nxt[w_base +: CHUNK] = w_s;
  end

  rc_add_chunk #(
    .N (CHUNK)
  ) u_chunk (
    .i_a     (w_a_sl),
    .i_b     (w_b_sl),
    .i_ci    (r_carry),
    .o_s     (w_s),
    .o_co    (w_co),
    .o_c_msb (w_c_msb)
  );

  // Slice sequencing, result accumulation and flag generation on the last slice.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_y     <= '0;
      r_co    <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_carry <= (bus.SnA == OP_SUB);
      r_co    <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_step) begin
      r_y     <= w_y_nxt;
      r_carry <= w_co;
      if (w_last) begin
        r_cnt  <= '0;
        r_co   <= w_co;
        r_ovf  <= w_co ^ w_c_msb;
        r_zero <= (w_y_nxt == '0);
        r_neg  <= w_y_nxt[WIDTH-1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.BUSY = (r_state == ST_RUN);
  assign bus.DONE = (r_state == ST_FIN);
  assign bus.Y    = r_y;
  assign bus.CO   = r_co;
  assign bus.ZERO = r_zero;
  assign bus.NEG  = r_neg;
  assign bus.OVF  = r_ovf;

endmodule
